// File: rtl/pic_top.sv
// pic_top: 8-input priority interrupt controller with master/slave cascade (optional macro PIC_AEOI_EN).
// Latency: IR edge to INT_Flag in 1 clk; vector driven 1 clk after the second INTA fall is sampled.
// Backpressure: none; host strobes are sampled every clk and a write commits when write_flag returns high.
module pic_top (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       chip_select,
    input  logic       write_flag,
    input  logic       read_flag,
    input  logic       A0,
    inout  wire  [7:0] data_Bus,
    inout  wire  [2:0] cascade_lines,
    input  logic       sp,
    input  logic       INTA,
    input  logic [7:0] interrupt_requests,
    output logic       INT_Flag
);

    typedef enum logic [2:0] {
        ST_UNINIT,
        ST_WAIT_ICW2,
        ST_WAIT_ICW3,
        ST_WAIT_ICW4,
        ST_READY
    } init_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_FIRST,
        PH_GAP,
        PH_SECOND
    } inta_phase_t;

    init_state_t state_q, state_d;
    inta_phase_t phase_q, phase_d;

    logic       ltim_q, ltim_d;
    logic       sngl_q, sngl_d;
    logic       ic4_q, ic4_d;
    logic [4:0] vec_base_q, vec_base_d;
    logic [7:0] icw3_q, icw3_d;
    logic [7:0] icw4_q, icw4_d;
    logic [7:0] imr_q, imr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] irr_q, irr_d;
    logic       rd_isr_q, rd_isr_d;
    logic [2:0] vec_n_q, vec_n_d;
    logic       vec_none_q, vec_none_d;
    logic       cas_drv_q, cas_drv_d;
    logic       int_flag_q, int_flag_d;

    logic [7:0] ir_q;
    logic       inta_q;
    logic       wr_pend;
    logic [7:0] wr_dat;
    logic       wr_a0;

    logic       commit;
    logic       is_icw1;
    logic       inta_fall;
    logic       inta_rise;
    logic [7:0] irr_upd;
    logic [7:0] pend;
    logic [2:0] win;
    logic       aeoi;
    logic       unused_icw4;

    // Mask of IRR bits that outrank the highest-priority in-service level (all bits if none).
    function automatic logic [7:0] above_isr(input logic [7:0] v);
        return (v & (~v + 8'd1)) - 8'd1;
    endfunction

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = i[2:0];
        end
        return idx;
    endfunction

`ifdef PIC_AEOI_EN
    assign aeoi        = icw4_q[1];
    assign unused_icw4 = ^{icw4_q[7:2], icw4_q[0]};
`else
    assign aeoi        = 1'b0;
    assign unused_icw4 = ^icw4_q;
`endif

    assign commit    = wr_pend && write_flag;
    assign is_icw1   = commit && !wr_a0 && wr_dat[4];
    assign inta_fall = inta_q && !INTA;
    assign inta_rise = !inta_q && INTA;

    // New IR edges land in IRR before the INTA winner is chosen in the same cycle.
    assign irr_upd = ltim_q ? interrupt_requests : (irr_q | (interrupt_requests & ~ir_q));
    assign pend    = irr_upd & ~imr_q & above_isr(isr_q);
    assign win     = lowest_idx(pend);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        ltim_d     = ltim_q;
        sngl_d     = sngl_q;
        ic4_d      = ic4_q;
        vec_base_d = vec_base_q;
        icw3_d     = icw3_q;
        icw4_d     = icw4_q;
        imr_d      = imr_q;
        isr_d      = isr_q;
        irr_d      = irr_upd;
        rd_isr_d   = rd_isr_q;
        vec_n_d    = vec_n_q;
        vec_none_d = vec_none_q;
        cas_drv_d  = cas_drv_q;

        if (is_icw1) begin
            ltim_d   = wr_dat[3];
            sngl_d   = wr_dat[1];
            ic4_d    = wr_dat[0];
            icw3_d   = 8'h00;
            icw4_d   = 8'h00;
            imr_d    = 8'h00;
            isr_d    = 8'h00;
            irr_d    = 8'h00;
            rd_isr_d = 1'b0;
            state_d  = ST_WAIT_ICW2;
            phase_d  = PH_IDLE;
            cas_drv_d = 1'b0;
        end else begin
            if (commit && wr_a0) begin
                case (state_q)
                    ST_WAIT_ICW2: begin
                        vec_base_d = wr_dat[7:3];
                        if (!sngl_q)    state_d = ST_WAIT_ICW3;
                        else if (ic4_q) state_d = ST_WAIT_ICW4;
                        else            state_d = ST_READY;
                    end
                    ST_WAIT_ICW3: begin
                        icw3_d  = wr_dat;
                        state_d = ic4_q ? ST_WAIT_ICW4 : ST_READY;
                    end
                    ST_WAIT_ICW4: begin
                        icw4_d  = wr_dat;
                        state_d = ST_READY;
                    end
                    ST_READY: imr_d = wr_dat;
                    default: ;
                endcase
            end else if (commit && state_q == ST_READY) begin
                if (!wr_dat[3]) begin
                    case (wr_dat[7:5])
                        3'b001:  isr_d = isr_q & (isr_q - 8'd1);
                        3'b011:  isr_d[wr_dat[2:0]] = 1'b0;
                        default: ;
                    endcase
                end else if (wr_dat[1]) begin
                    rd_isr_d = wr_dat[0];
                end
            end

            case (phase_q)
                PH_IDLE: begin
                    if (inta_fall && state_q == ST_READY &&
                        (sp || cascade_lines == icw3_q[2:0])) begin
                        phase_d    = PH_FIRST;
                        vec_none_d = ~|pend;
                        vec_n_d    = win;
                        cas_drv_d  = 1'b0;
                        if (|pend) begin
                            isr_d[win] = 1'b1;
                            irr_d[win] = 1'b0;
                            cas_drv_d  = sp && !sngl_q && icw3_q[win];
                        end
                    end
                end
                PH_FIRST:  if (inta_rise) phase_d = PH_GAP;
                PH_GAP:    if (inta_fall) phase_d = PH_SECOND;
                PH_SECOND: begin
                    if (inta_rise) begin
                        phase_d   = PH_IDLE;
                        cas_drv_d = 1'b0;
                        if (aeoi && !vec_none_q) isr_d[vec_n_q] = 1'b0;
                    end
                end
                default: phase_d = PH_IDLE;
            endcase
        end

        int_flag_d = (state_d == ST_READY) && (phase_d == PH_IDLE) &&
                     (|(irr_d & ~imr_d & above_isr(isr_d)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_UNINIT;
            phase_q    <= PH_IDLE;
            ltim_q     <= 1'b0;
            sngl_q     <= 1'b0;
            ic4_q      <= 1'b0;
            vec_base_q <= 5'd0;
            icw3_q     <= 8'h00;
            icw4_q     <= 8'h00;
            imr_q      <= 8'h00;
            isr_q      <= 8'h00;
            irr_q      <= 8'h00;
            rd_isr_q   <= 1'b0;
            vec_n_q    <= 3'd0;
            vec_none_q <= 1'b0;
            cas_drv_q  <= 1'b0;
            int_flag_q <= 1'b0;
            ir_q       <= 8'h00;
            inta_q     <= 1'b1;
            wr_pend    <= 1'b0;
            wr_dat     <= 8'h00;
            wr_a0      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            ltim_q     <= ltim_d;
            sngl_q     <= sngl_d;
            ic4_q      <= ic4_d;
            vec_base_q <= vec_base_d;
            icw3_q     <= icw3_d;
            icw4_q     <= icw4_d;
            imr_q      <= imr_d;
            isr_q      <= isr_d;
            irr_q      <= irr_d;
            rd_isr_q   <= rd_isr_d;
            vec_n_q    <= vec_n_d;
            vec_none_q <= vec_none_d;
            cas_drv_q  <= cas_drv_d;
            int_flag_q <= int_flag_d;
            ir_q       <= interrupt_requests;
            inta_q     <= INTA;
            if (!chip_select && !write_flag) begin
                wr_pend <= 1'b1;
                wr_dat  <= data_Bus;
                wr_a0   <= A0;
            end else if (write_flag) begin
                wr_pend <= 1'b0;
            end
        end
    end

    // Bus enables are combinational on the strobes so the pins release as soon as the host lets go.
    logic       rd_oe;
    logic       vec_oe;
    logic       cas_oe;
    logic [7:0] bus_dat;

    assign rd_oe   = rst_n && !chip_select && !read_flag;
    assign vec_oe  = rst_n && (phase_q == PH_SECOND) && !INTA && !cas_drv_q && !is_icw1;
    assign cas_oe  = rst_n && cas_drv_q && sp && (phase_q != PH_IDLE) && !is_icw1;
    assign bus_dat = vec_oe ? {vec_base_q, vec_n_q} :
                     A0     ? imr_q :
                     rd_isr_q ? isr_q : irr_q;

    assign data_Bus      = (vec_oe || rd_oe) ? bus_dat : 8'bz;
    assign cascade_lines = cas_oe ? vec_n_q : 3'bz;
    assign INT_Flag      = int_flag_q;

endmodule

// File: tb/tb_pic_top.sv
// tb_pic_top: directed bench for pic_top; expected observations are queued and checked by a monitor.
// Latency: each queued expectation is compared on the next falling clk edge.
// Backpressure: none; undriven bus lines are pulled high so a released bus reads as all ones.
`timescale 1ns/1ps
module tb_pic_top;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       chip_select = 1'b1;
    logic       write_flag = 1'b1;
    logic       read_flag = 1'b1;
    logic       a0 = 1'b0;
    logic       sp = 1'b1;
    logic       inta = 1'b1;
    logic [7:0] ir = 8'h00;
    wire        int_flag;
    tri1  [7:0] data_bus;
    tri1  [2:0] cas;

    logic [7:0] tb_d = 8'h00;
    logic       tb_d_oe = 1'b0;
    logic [2:0] tb_c = 3'd0;
    logic       tb_c_oe = 1'b0;

    assign data_bus = tb_d_oe ? tb_d : 8'bz;
    assign cas      = tb_c_oe ? tb_c : 3'bz;

    always #5 clk = ~clk;

    pic_top dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .chip_select       (chip_select),
        .write_flag        (write_flag),
        .read_flag         (read_flag),
        .A0                (a0),
        .data_Bus          (data_bus),
        .cascade_lines     (cas),
        .sp                (sp),
        .INTA              (inta),
        .interrupt_requests(ir),
        .INT_Flag          (int_flag)
    );

    // Scoreboard: kind 0 = INT_Flag, 1 = data_Bus, 2 = cascade_lines.
    int         kq[$];
    logic [7:0] eq[$];
    string      nq[$];
    int         total = 0;
    int         bad = 0;

    task automatic expect_obs(input int kind, input logic [7:0] exp, input string name);
        kq.push_back(kind);
        eq.push_back(exp);
        nq.push_back(name);
    endtask

    initial begin : monitor
        int         k;
        logic [7:0] e;
        logic [7:0] a;
        string      n;
        forever begin
            @(negedge clk);
            while (kq.size() > 0) begin
                k = kq.pop_front();
                e = eq.pop_front();
                n = nq.pop_front();
                case (k)
                    0:       a = {7'd0, int_flag};
                    1:       a = data_bus;
                    default: a = {5'd0, cas};
                endcase
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: got %02h expected %02h", n, a, e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        chip_select = 1'b0; write_flag = 1'b0; a0 = a; tb_d = d; tb_d_oe = 1'b1;
        step(1);
        chip_select = 1'b1; write_flag = 1'b1; tb_d_oe = 1'b0;
        step(2);
    endtask

    task automatic rd(input logic a, input logic [7:0] e, input string n);
        chip_select = 1'b0; read_flag = 1'b0; a0 = a;
        expect_obs(1, e, n);
        step(1);
        chip_select = 1'b1; read_flag = 1'b1;
        step(1);
    endtask

    task automatic check_int(input logic e, input string n);
        expect_obs(0, {7'd0, e}, n);
        step(1);
    endtask

    task automatic init(input logic [7:0] icw1, input logic [7:0] icw2,
                        input logic [7:0] icw3, input logic [7:0] icw4);
        wr(1'b0, icw1);
        wr(1'b1, icw2);
        if (!icw1[1]) wr(1'b1, icw3);
        if (icw1[0])  wr(1'b1, icw4);
    endtask

    task automatic inta_pair(input logic chk_cas, input logic [2:0] exp_cas,
                             input logic [7:0] exp_dat, input string n);
        inta = 1'b0;
        step(1);
        if (chk_cas) expect_obs(2, {5'd0, exp_cas}, {n, "_cas1"});
        step(1);
        inta = 1'b1;
        step(2);
        inta = 1'b0;
        step(1);
        expect_obs(1, exp_dat, {n, "_vec"});
        if (chk_cas) expect_obs(2, {5'd0, exp_cas}, {n, "_cas2"});
        step(1);
        inta = 1'b1;
        step(2);
    endtask

    initial begin : stim
        int wait_cyc;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);

        // Reset state and UNINIT behaviour
        expect_obs(0, 8'h00, "rst_int");
        expect_obs(1, 8'hFF, "rst_dat_tri");
        expect_obs(2, 8'h07, "rst_cas_tri");
        step(1);
        rd(1'b0, 8'h00, "rst_irr");
        rd(1'b1, 8'h00, "rst_imr");
        wr(1'b1, 8'hFF);
        rd(1'b1, 8'h00, "uninit_imr_ignored");
        ir = 8'h01;
        step(3);
        check_int(1'b0, "uninit_int");
        ir = 8'h00;
        step(1);

        // Master single with ICW4, IR3 -> vector 0x0B
        init(8'h13, 8'h08, 8'h00, 8'h01);
        ir = 8'h08;
        step(2);
        check_int(1'b1, "t1_int");
        inta_pair(1'b0, 3'd0, 8'h0B, "t1");
        check_int(1'b0, "t1_int_dropped");
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h08, "t1_isr");
        wr(1'b0, 8'h0A);
        rd(1'b0, 8'h00, "t1_irr");

        // No pending request at INTA -> base|7, ISR untouched
        inta_pair(1'b0, 3'd0, 8'h0F, "none");
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h08, "none_isr");
        wr(1'b0, 8'h20);
        rd(1'b0, 8'h00, "ns_eoi_single");
        ir = 8'h00;
        step(1);

        // ICW4 AEOI bit
        init(8'h13, 8'h08, 8'h00, 8'h03);
        ir = 8'h04;
        step(2);
        inta_pair(1'b0, 3'd0, 8'h0A, "aeoi");
        wr(1'b0, 8'h0B);
`ifdef PIC_AEOI_EN
        rd(1'b0, 8'h00, "aeoi_isr");
`else
        rd(1'b0, 8'h04, "aeoi_isr");
`endif
        ir = 8'h00;
        step(1);

        // Masking via OCW1
        init(8'h12, 8'h08, 8'h00, 8'h00);
        wr(1'b1, 8'h04);
        ir = 8'h04;
        step(3);
        check_int(1'b0, "masked_int");
        wr(1'b1, 8'h00);
        check_int(1'b1, "unmasked_int");
        ir = 8'h00;
        step(1);

        // Nesting and EOI
        init(8'h12, 8'h08, 8'h00, 8'h00);
        ir = 8'h20;
        step(2);
        check_int(1'b1, "ir5_int");
        inta_pair(1'b0, 3'd0, 8'h0D, "ir5");
        ir = 8'h60;
        step(3);
        check_int(1'b0, "ir6_blocked");
        ir = 8'h62;
        step(2);
        check_int(1'b1, "ir1_int");
        inta_pair(1'b0, 3'd0, 8'h09, "ir1");
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h22, "isr_nested");
        wr(1'b0, 8'h20);
        rd(1'b0, 8'h20, "ns_eoi_clears_ir1");
        check_int(1'b0, "ir6_still_blocked");
        wr(1'b0, 8'h65);
        rd(1'b0, 8'h00, "spec_eoi_ir5");
        check_int(1'b1, "ir6_now_int");
        ir = 8'h00;
        step(1);

        // Register reads and OCW3 selection
        init(8'h12, 8'h08, 8'h00, 8'h00);
        wr(1'b1, 8'hA5);
        wr(1'b0, 8'h0A);
        ir = 8'h10;
        step(2);
        rd(1'b0, 8'h10, "irr_read");
        rd(1'b1, 8'hA5, "imr_read");
        wr(1'b0, 8'h0B);
        wr(1'b0, 8'h08);
        rd(1'b0, 8'h00, "ocw3_keep_isr");
        ir = 8'h00;
        step(1);

        // Level-triggered mode
        init(8'h1A, 8'h08, 8'h00, 8'h00);
        ir = 8'h01;
        step(2);
        rd(1'b0, 8'h01, "lvl_on");
        ir = 8'h00;
        step(2);
        rd(1'b0, 8'h00, "lvl_off");

        // Master with slaves: cascade id instead of vector
        init(8'h10, 8'h08, 8'h3F, 8'h00);
        ir = 8'h02;
        step(2);
        check_int(1'b1, "mcas_int");
        inta_pair(1'b1, 3'd1, 8'hFF, "mcas");
        expect_obs(2, 8'h07, "mcas_released");
        step(1);
        wr(1'b0, 8'h20);
        ir = 8'h42;
        step(2);
        inta_pair(1'b0, 3'd0, 8'h0E, "mcas_local");
        expect_obs(2, 8'h07, "mcas_local_cas_tri");
        step(1);
        ir = 8'h00;
        step(1);

        // Slave: responds only to its own cascade id
        sp = 1'b0;
        init(8'h10, 8'h10, 8'h01, 8'h00);
        ir = 8'h80;
        step(2);
        check_int(1'b1, "slv_int");
        tb_c = 3'd2;
        tb_c_oe = 1'b1;
        inta_pair(1'b0, 3'd0, 8'hFF, "slv_other_id");
        check_int(1'b1, "slv_int_kept");
        tb_c = 3'd1;
        inta_pair(1'b0, 3'd0, 8'h17, "slv");
        tb_c_oe = 1'b0;
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h80, "slv_isr");
        ir = 8'h00;
        sp = 1'b1;
        step(1);

        // Reset in the middle of an INTA sequence
        init(8'h10, 8'h08, 8'hFF, 8'h00);
        wr(1'b1, 8'h80);
        ir = 8'h04;
        step(2);
        inta = 1'b0;
        step(1);
        expect_obs(2, 8'h02, "pre_rst_cas");
        step(1);
        ir = 8'h24;
        step(2);
        rst_n = 1'b0;
        chip_select = 1'b0;
        read_flag = 1'b0;
        a0 = 1'b1;
        expect_obs(0, 8'h00, "in_rst_int");
        expect_obs(1, 8'hFF, "in_rst_dat_tri");
        expect_obs(2, 8'h07, "in_rst_cas_tri");
        step(1);
        chip_select = 1'b1;
        read_flag = 1'b1;
        inta = 1'b1;
        ir = 8'h00;
        step(1);
        rst_n = 1'b1;
        step(1);
        expect_obs(2, 8'h07, "post_rst_cas_tri");
        step(1);
        rd(1'b0, 8'h00, "post_rst_irr");
        rd(1'b1, 8'h00, "post_rst_imr");
        init(8'h12, 8'h08, 8'h00, 8'h00);
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h00, "post_rst_isr");
        check_int(1'b0, "post_rst_int");

        wait_cyc = 0;
        while (kq.size() > 0 && wait_cyc < 20) begin
            step(1);
            wait_cyc++;
        end
        if (kq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", kq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pic_top.md
PIC_TOP -- requirements
Module: pic_top

Interface
REQ-001 No parameters; all behaviour is fixed or set by initialization/operation command words (ICWs/OCWs).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 chip_select  input  1  active-low device select for register access.
REQ-005 write_flag  input  1  active-low write strobe.
REQ-006 read_flag  input  1  active-low read strobe.
REQ-007 A0  input  1  register address bit.
REQ-008 data_Bus  inout  8  bidirectional data; tri-stated unless reading or driving a vector.
REQ-009 cascade_lines  inout  3  cascade ID; driven by master, input on slave.
REQ-010 sp  input  1  1 = master, 0 = slave.
REQ-011 INTA  input  1  active-low interrupt acknowledge.
REQ-012 interrupt_requests  input  8  IR7..IR0 request lines.
REQ-013 INT_Flag  output  1  active-high interrupt request to CPU or master.

Function
REQ-014 All inputs are sampled on clk; a write latches data_Bus/A0 each cycle chip_select=0 and write_flag=0, and commits on the first cycle write_flag is sampled 1 after that.
REQ-015 A committed write with A0=0 and D4=1 is ICW1 in any state: store LTIM(D3), SNGL(D1), IC4(D0); clear IMR, ISR, IRR; enter WAIT_ICW2.
REQ-016 Init FSM: UNINIT -> WAIT_ICW2 -> WAIT_ICW3 (only if SNGL=0) -> WAIT_ICW4 (only if IC4=1) -> READY; each step advances on an A0=1 write.
REQ-017 In UNINIT, every write other than ICW1 is ignored, and INT_Flag stays 0 until READY.
REQ-018 ICW2[7:3] is the vector base. Master ICW3 is the slave-present bitmap; slave ICW3[2:0] is its cascade ID.
REQ-019 ICW4 bit1 is AEOI, gated per REQ-036/037; other ICW4 bits are stored but have no effect. If IC4=0, ICW4 is all zeros.
REQ-020 In READY: A0=1 write -> OCW1 (IMR). A0=0, D4=0, D3=0 -> OCW2. A0=0, D4=0, D3=1 -> OCW3.
REQ-021 OCW2 D7:D5=001 clears the highest-priority set ISR bit (non-specific EOI); 011 clears ISR[D2:D0] (specific EOI); other codes are ignored.
REQ-022 OCW3 D1:D0=10 selects IRR for reads, 11 selects ISR; other values keep the current selection. Selection resets to IRR.
REQ-023 Read with chip_select=0, read_flag=0: A0=0 drives the selected IRR/ISR, A0=1 drives IMR. data_Bus is driven only while both are low.
REQ-024 Edge mode (LTIM=0): IRR bit sets on a sampled 0->1 of its IR and holds until acknowledged. Level mode (LTIM=1): IRR bit follows IR level.
REQ-025 Fixed priority, IR0 highest. INT_Flag=1 when some bit of IRR & ~IMR has higher priority than the highest set ISR bit; registered, asserted within 2 clk of the IR rising edge.
REQ-026 First sampled INTA falling edge: freeze the winning level n, set ISR[n], clear IRR[n], drop INT_Flag.
REQ-027 Master with SNGL=0: if ICW3[n]=1, drive cascade_lines=n from the first INTA until the second INTA rises, and do not drive data_Bus; otherwise cascade_lines stay tri-stated.
REQ-028 Second INTA low: drive data_Bus={ICW2[7:3], n} unless REQ-027 suppresses it; release data_Bus when INTA rises.
REQ-029 Slave (sp=0) acts on INTA only when cascade_lines equals its ICW3[2:0]; otherwise it ignores INTA. A slave never drives cascade_lines.
REQ-030 If no request is pending at the first INTA, ISR is unchanged and the vector is {ICW2[7:3],3'b111}.
REQ-031 If an IR edge coincides with an INTA edge, the IRR update happens before priority resolution in the same cycle.
REQ-032 An ICW1 during an INTA sequence aborts it: data_Bus and cascade_lines are released immediately.

Reset
REQ-033 rst_n=0 asynchronously: FSM=UNINIT; IRR, ISR, IMR, ICW registers = 0; read selection = IRR; INTA phase cleared.
REQ-034 During reset: INT_Flag=0; data_Bus and cascade_lines tri-stated.
REQ-035 After rst_n deasserts, operation resumes on the next clk edge.

Configuration
REQ-036 Macro PIC_AEOI_EN defined: ICW4 bit1=1 clears ISR[n] when the second INTA rises.
REQ-037 PIC_AEOI_EN undefined: ICW4 bit1 is ignored; ISR clears only via OCW2.

Verification
REQ-038 Master, sp=1: ICW1=0x13, ICW2=0x08, IC4 ICW4=0x01; raise IR3 -> INT_Flag=1; two INTA pulses -> data_Bus=0x0B; ISR=0x08.
REQ-039 Master ICW1=0x10, ICW2=0x08, ICW3=0x3F; raise IR1, two INTA pulses -> cascade_lines=3'd1 and data_Bus tri-stated. Slave ICW1=0x10, ICW2=0x10, ICW3=0x01; raise slave IR7, cascade_lines=1, two INTA pulses -> slave data_Bus=0x17.
REQ-040 IMR=0x04 via OCW1; raise IR2 -> INT_Flag stays 0. Write IMR=0x00 -> INT_Flag=1.
REQ-041 IR5 in service; raise IR6 -> no INT. Raise IR1 -> INT_Flag=1. OCW2=0x20 clears ISR bit1 first.
REQ-042 OCW3=0x0A, raise IR4 unacked -> A0=0 read returns 0x10. A0=1 read returns IMR.
REQ-043 rst_n pulsed mid-INTA -> INT_Flag=0, data_Bus and cascade_lines tri-stated, IRR=ISR=IMR=0.
